uart_rx: RTL and testbench



---
 rtl/uart_rx.sv | 140 ++++++++++++++
 tb/tb_uart_rx.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 2-flop input synchroniser, mid-bit sampling FSM, and an
// AXI-stream master output with single-cycle framing/overrun status pulses.
module uart_rx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [DATA_WIDTH-1:0] output_axi_tdata,
  output logic                  output_axi_tvalid,
  input  logic                  output_axi_tready,
  input  logic                  rxd,
  output logic                  busy,
  output logic                  overrun_error,
  output logic                  frame_error,
  input  logic [15:0]           prescale
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  logic                  rxd_q1, rxd_s;
  state_t                state_q, state_d;
  logic [15:0]           prescale_q, prescale_d;
  logic [18:0]           timer_q, timer_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] tdata_d;
  logic                  tvalid_d, busy_d, overrun_d, frame_d;
  logic [18:0]           half_time, bit_time;

  // Half bit uses the live prescale (latched at the same edge); full bit uses the latched copy.
  assign half_time = {1'b0, prescale, 2'b00} - 19'd1;
  assign bit_time  = {prescale_q, 3'b000} - 19'd1;

  // Two-flop synchroniser for the asynchronous serial input, idling high.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_q1 <= 1'b1;
      rxd_s  <= 1'b1;
    end else begin
      rxd_q1 <= rxd;
      rxd_s  <= rxd_q1;
    end
  end

  // Next-state, datapath and output decode for the receive FSM.
  always_comb begin
    state_d    = state_q;
    prescale_d = prescale_q;
    timer_d    = timer_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tdata_d    = output_axi_tdata;
    tvalid_d   = output_axi_tvalid && !output_axi_tready;
    overrun_d  = 1'b0;
    frame_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rxd_s && prescale != '0) begin
          prescale_d = prescale;
          timer_d    = half_time;
          state_d    = START;
        end
      end
      START: begin
        if (timer_q == '0) begin
          if (!rxd_s) begin
            timer_d   = bit_time;
            bit_cnt_d = '0;
            state_d   = DATA;
          end else begin
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q - 19'd1;
        end
      end
      DATA: begin
        if (timer_q == '0) begin
          shift_d             = shift_q >> 1;
          shift_d[DATA_WIDTH-1] = rxd_s;
          timer_d             = bit_time;
          if (bit_cnt_q == LAST_BIT) begin
            state_d = STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          timer_d = timer_q - 19'd1;
        end
      end
      STOP: begin
        if (timer_q == '0) begin
          if (rxd_s) begin
            tdata_d   = shift_q;
            tvalid_d  = 1'b1;
            overrun_d = output_axi_tvalid && !output_axi_tready;
          end else begin
            frame_d = 1'b1;
          end
          state_d = IDLE;
        end else begin
          timer_d = timer_q - 19'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= IDLE;
      prescale_q        <= '0;
      timer_q           <= '0;
      bit_cnt_q         <= '0;
      shift_q           <= '0;
      output_axi_tdata  <= '0;
      output_axi_tvalid <= 1'b0;
      busy              <= 1'b0;
      overrun_error     <= 1'b0;
      frame_error       <= 1'b0;
    end else begin
      state_q           <= state_d;
      prescale_q        <= prescale_d;
      timer_q           <= timer_d;
      bit_cnt_q         <= bit_cnt_d;
      shift_q           <= shift_d;
      output_axi_tdata  <= tdata_d;
      output_axi_tvalid <= tvalid_d;
      busy              <= busy_d;
      overrun_error     <= overrun_d;
      frame_error       <= frame_d;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table of single frames plus directed
// sequences for back-to-back, glitch, overrun, reset and prescale==0 cases.
module tb_uart_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  tdata;
  logic        tvalid;
  logic        tready;
  logic        rxd;
  logic        busy;
  logic        ov;
  logic        fe;
  logic [15:0] prescale;

  uart_rx #(.DATA_WIDTH(8)) dut (
    .clk               (clk),
    .rst               (rst),
    .output_axi_tdata  (tdata),
    .output_axi_tvalid (tvalid),
    .output_axi_tready (tready),
    .rxd               (rxd),
    .busy              (busy),
    .overrun_error     (ov),
    .frame_error       (fe),
    .prescale          (prescale)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Monitor state: accepted words, pulse counts, busy statistics.
  logic [7:0] words [0:63];
  int n_words = 0, n_fe = 0, n_ov = 0, n_busy = 0, n_busy_fall = 0, n_wide = 0;
  logic fe_prev = 1'b0, ov_prev = 1'b0, busy_prev = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (tvalid && tready && n_words < 64) begin
        words[n_words] = tdata;
        n_words++;
      end
      if (fe) n_fe++;
      if (ov) n_ov++;
      if (busy) n_busy++;
      if (busy_prev && !busy) n_busy_fall++;
      if ((fe && fe_prev) || (ov && ov_prev)) n_wide++;
    end
    fe_prev   = fe;
    ov_prev   = ov;
    busy_prev = busy;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input int cyc);
    rxd = b;
    repeat (cyc) @(negedge clk);
  endtask

  // A bad stop bit is held low for 3/4 of a bit so the break re-detect is rejected as a glitch.
  task automatic send_frame(input logic [7:0] d, input logic stop_ok, input int p);
    int t;
    t = p * 8;
    send_bit(1'b0, t);
    for (int i = 0; i < 8; i++) send_bit(d[i], t);
    if (stop_ok) begin
      send_bit(1'b1, t);
    end else begin
      send_bit(1'b0, (3 * t) / 4);
      send_bit(1'b1, t / 4);
    end
  endtask

  typedef struct {
    int         p;
    logic [7:0] data;
    logic       stop_ok;
    int         exp_words;
    int         exp_fe;
    int         exp_busy;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int w0, f0, o0, b0, bf0;

    vecs[0] = '{p: 1, data: 8'h5A, stop_ok: 1'b1, exp_words: 1, exp_fe: 0, exp_busy: 76};
    vecs[1] = '{p: 2, data: 8'hC3, stop_ok: 1'b1, exp_words: 1, exp_fe: 0, exp_busy: 152};
    vecs[2] = '{p: 4, data: 8'h3C, stop_ok: 1'b0, exp_words: 0, exp_fe: 1, exp_busy: 320};
    vecs[3] = '{p: 1, data: 8'h00, stop_ok: 1'b1, exp_words: 1, exp_fe: 0, exp_busy: 76};
    vecs[4] = '{p: 3, data: 8'hA5, stop_ok: 1'b1, exp_words: 1, exp_fe: 0, exp_busy: 228};
    vecs[5] = '{p: 1, data: 8'hFF, stop_ok: 1'b1, exp_words: 1, exp_fe: 0, exp_busy: 76};

    rst = 1'b1; rxd = 1'b1; tready = 1'b1; prescale = 16'd1;
    idle_cycles(3);
    check("reset_tdata", {24'd0, tdata}, 32'h0);
    check("reset_tvalid", {31'd0, tvalid}, 32'h0);
    check("reset_busy", {31'd0, busy}, 32'h0);
    check("reset_frame_error", {31'd0, fe}, 32'h0);
    check("reset_overrun", {31'd0, ov}, 32'h0);
    rst = 1'b0;
    idle_cycles(4);

    // Table-driven single frames.
    for (int v = 0; v < 6; v++) begin
      w0 = n_words; f0 = n_fe; o0 = n_ov; b0 = n_busy;
      prescale = vecs[v].p[15:0];
      tready = 1'b1;
      send_frame(vecs[v].data, vecs[v].stop_ok, vecs[v].p);
      idle_cycles(16 * vecs[v].p + 4);
      check($sformatf("vec%0d_words", v), n_words - w0, vecs[v].exp_words);
      if (vecs[v].exp_words == 1)
        check($sformatf("vec%0d_data", v), {24'd0, words[w0]}, {24'd0, vecs[v].data});
      check($sformatf("vec%0d_frame_error", v), n_fe - f0, vecs[v].exp_fe);
      check($sformatf("vec%0d_overrun", v), n_ov - o0, 0);
      check($sformatf("vec%0d_busy_cycles", v), n_busy - b0, vecs[v].exp_busy);
      check($sformatf("vec%0d_tvalid_idle", v), {31'd0, tvalid}, 32'h0);
    end

    // Back-to-back frames with one stop bit.
    w0 = n_words; bf0 = n_busy_fall;
    prescale = 16'd2;
    send_frame(8'h00, 1'b1, 2);
    send_frame(8'hFF, 1'b1, 2);
    idle_cycles(40);
    check("b2b_words", n_words - w0, 2);
    check("b2b_first", {24'd0, words[w0]}, 32'h00);
    check("b2b_second", {24'd0, words[w0 + 1]}, 32'hFF);
    check("b2b_busy_falls", n_busy_fall - bf0, 2);

    // Short low glitch is rejected at the start-bit midpoint.
    w0 = n_words; f0 = n_fe; b0 = n_busy;
    send_bit(1'b0, 3);
    send_bit(1'b1, 30);
    check("glitch_words", n_words - w0, 0);
    check("glitch_frame_error", n_fe - f0, 0);
    check("glitch_busy_cycles", n_busy - b0, 8);

    // Overrun: second word replaces an unaccepted first word.
    w0 = n_words; o0 = n_ov;
    prescale = 16'd1;
    tready = 1'b0;
    send_frame(8'h11, 1'b1, 1);
    idle_cycles(16);
    check("ovr_first_tvalid", {31'd0, tvalid}, 32'h1);
    check("ovr_first_tdata", {24'd0, tdata}, 32'h11);
    send_frame(8'h22, 1'b1, 1);
    idle_cycles(16);
    check("ovr_pulse", n_ov - o0, 1);
    check("ovr_second_tvalid", {31'd0, tvalid}, 32'h1);
    check("ovr_second_tdata", {24'd0, tdata}, 32'h22);
    check("ovr_no_transfer_yet", n_words - w0, 0);
    tready = 1'b1;
    idle_cycles(4);
    check("ovr_drain_words", n_words - w0, 1);
    check("ovr_drain_data", {24'd0, words[w0]}, 32'h22);
    check("ovr_drain_tvalid", {31'd0, tvalid}, 32'h0);

    // Reset in the middle of data bit 4 of 0xA5, then a clean 0x96.
    send_frame(8'h5A, 1'b1, 1);
    idle_cycles(16);
    w0 = n_words; f0 = n_fe;
    send_bit(1'b0, 8);
    for (int i = 0; i < 4; i++) send_bit(i[0] ? 1'b0 : 1'b1, 8);
    send_bit(1'b0, 3);
    rst = 1'b1;
    idle_cycles(2);
    check("rst_mid_tdata", {24'd0, tdata}, 32'h0);
    check("rst_mid_tvalid", {31'd0, tvalid}, 32'h0);
    check("rst_mid_busy", {31'd0, busy}, 32'h0);
    rst = 1'b0;
    rxd = 1'b1;
    idle_cycles(20);
    w0 = n_words;
    send_frame(8'h96, 1'b1, 1);
    idle_cycles(16);
    check("rst_after_words", n_words - w0, 1);
    check("rst_after_data", {24'd0, words[w0]}, 32'h96);
    check("rst_after_frame_error", n_fe - f0, 0);

    // prescale==0 never leaves IDLE.
    b0 = n_busy; w0 = n_words;
    prescale = 16'd0;
    send_bit(1'b0, 20);
    send_bit(1'b1, 10);
    check("p0_busy_cycles", n_busy - b0, 0);
    check("p0_words", n_words - w0, 0);

    check("pulse_width_single", n_wide, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
